// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
`timescale 1ns/1ps
module uart_rx #(
   parameter int clk_freq = 1000000,
   parameter int baud     = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       done_rx,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int CLK_COUNT = clk_freq / baud;
   localparam int HALF      = CLK_COUNT / 2;
   localparam int CNT_W     = $clog2(CLK_COUNT) + 1;

   // Counter restarts at 0 the cycle after each sample, so a full bit ends at CLK_COUNT-1.
   localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLK_COUNT - 1);
   localparam logic [CNT_W-1:0] START_END = CNT_W'(HALF - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif
   localparam logic [2:0] STOP   = 3'd4;

`ifdef UART_RX_PARITY_EN
   function automatic logic even_ok(input logic [7:0] data, input logic par);
      even_ok = ~(^{data, par});
   endfunction
`endif

   logic [1:0]       sync_q, sync_d;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       dout_q, dout_d;
   logic             armed_q, armed_d;
   logic             done_q, done_d;
   logic             ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic             par_q, par_d;
   logic             perr_q, perr_d;
`endif
   logic             rx_s;

   assign rx_s = sync_q[1];

   always_comb begin
      sync_d   = {sync_q[0], rx};
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      dout_d   = dout_q;
      armed_d  = armed_q;
      done_d   = 1'b0;
      ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d    = par_q;
      perr_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            armed_d = armed_q | rx_s;
            // A line held low (break, or reset mid-frame) must go high before a new start is accepted.
            if (armed_q && !rx_s) begin
               state_d = START;
               armed_d = 1'b0;
               bit_d   = 3'd0;
            end
         end
         START: begin
            if (cnt_q == START_END) begin
               cnt_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               par_d   = rx_s;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            // Leaving at the stop-bit centre gives half a bit of slack for the next start edge.
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               state_d = IDLE;
               armed_d = 1'b0;
               if (!rx_s) begin
                  ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (!even_ok(shift_q, par_q)) begin
                  perr_d = 1'b1;
`endif
               end else begin
                  dout_d = shift_q;
                  done_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            armed_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q  <= 2'b11;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         dout_q  <= 8'h00;
         armed_q <= 1'b0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         armed_q <= armed_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign dout      = dout_q;
   assign done_rx   = done_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (104 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int BIT = 104;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 991 + BIT;
`else
   localparam int LAT = 991;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] dout;
   logic       done_rx, frame_err, parity_err, busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   int done_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
   int excl_viol = 0, width_viol = 0;
   logic prev_done = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;
   logic [7:0] dq[$];
   int         dcyc[$];

   uart_rx dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .dout(dout),
      .done_rx(done_rx), .frame_err(frame_err),
      .parity_err(parity_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done_rx) begin
         done_cnt++;
         dq.push_back(dout);
         dcyc.push_back(cyc);
      end
      if (frame_err) ferr_cnt++;
      if (parity_err) perr_cnt++;
      if (int'(done_rx) + int'(frame_err) + int'(parity_err) > 1) excl_viol++;
      if ((done_rx && prev_done) || (frame_err && prev_ferr) || (parity_err && prev_perr)) width_viol++;
      prev_done = done_rx;
      prev_ferr = frame_err;
      prev_perr = parity_err;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every drive lands 1ns after a rising edge and lasts exactly n clocks.
   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
      hold(1'b0, BIT);
      for (int i = 0; i < 8; i++) hold(b[i], BIT);
`ifdef UART_RX_PARITY_EN
      hold(par_bit, BIT);
`else
      if (par_bit === 1'bx) hold(1'b1, 0);
`endif
      hold(stop_bit, BIT);
   endtask

   int t0, d0, f0, p0;

   initial begin
      rst_n = 1'b0;
      rx = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("rst_dout", 32'(dout), 32'h00);
      check("rst_done", 32'(done_rx), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      check("rst_perr", 32'(parity_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      hold(1'b1, 20);

      // Scenario 1: single byte, latency from the rx falling edge
      d0 = done_cnt; f0 = ferr_cnt;
      t0 = cyc;
      send_frame(8'hA5, 1'b1, ^8'hA5);
      hold(1'b1, 20);
      check("s1_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("s1_latency", (dcyc.size() > 0) ? 32'(dcyc[dcyc.size()-1] - t0) : 32'hFFFF_FFFF, 32'(LAT));
      check("s1_dout", 32'(dout), 32'hA5);
      check("s1_ferr", 32'(ferr_cnt - f0), 32'd0);

      // Scenario 2: back-to-back frames with no idle gap
      d0 = done_cnt;
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      hold(1'b1, 30);
      check("s2_done_cnt", 32'(done_cnt - d0), 32'd2);
      if (dq.size() >= 2) begin
         check("s2_first", 32'(dq[dq.size()-2]), 32'h00);
         check("s2_second", 32'(dq[dq.size()-1]), 32'hFF);
         check("s2_spacing", 32'(dcyc[dcyc.size()-1] - dcyc[dcyc.size()-2]), 32'(10 * BIT + (LAT - 991)));
      end else begin
         check("s2_queue", 32'(dq.size()), 32'd2);
      end

      // Scenario 3: 20-clock glitch on the idle line
      d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
      t0 = cyc;
      hold(1'b0, 20);
      rx = 1'b1;
      while (cyc < t0 + 54) begin @(posedge clk); #1; end
      check("s3_busy_at_H", 32'(busy), 32'd1);
      while (cyc < t0 + 55) begin @(posedge clk); #1; end
      check("s3_busy_after_H", 32'(busy), 32'd0);
      hold(1'b1, 300);
      check("s3_pulses", 32'(done_cnt - d0 + ferr_cnt - f0 + perr_cnt - p0), 32'd0);

      // Scenario 4: bad stop bit followed by a long break
      d0 = done_cnt; f0 = ferr_cnt;
      hold(1'b0, BIT);
      for (int i = 0; i < 8; i++) hold(t0[0] | (8'h3C >> i) & 8'h01 ? 1'b1 : 1'b0, BIT);
`ifdef UART_RX_PARITY_EN
      hold(^8'h3C, BIT);
`endif
      hold(1'b0, BIT + 2000);
      check("s4_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
      check("s4_no_done", 32'(done_cnt - d0), 32'd0);
      check("s4_dout_kept", 32'(dout), 32'hFF);
      check("s4_busy_break", 32'(busy), 32'd0);
      hold(1'b1, 50);
      send_frame(8'h81, 1'b1, ^8'h81);
      hold(1'b1, 20);
      check("s4_recover", 32'(dout), 32'h81);

      // Scenario 5: reset in the middle of bit 4, transmitter abandons the frame
      d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
      hold(1'b0, BIT);
      for (int i = 0; i < 4; i++) hold((8'h55 >> i) & 8'h01 ? 1'b1 : 1'b0, BIT);
      hold(1'b1, 50);
      rst_n = 1'b0;
      hold(1'b1, 1);
      rst_n = 1'b1;
      check("s5_dout_rst", 32'(dout), 32'h00);
      check("s5_busy_rst", 32'(busy), 32'd0);
      hold(1'b1, 1200);
      check("s5_no_pulse", 32'(done_cnt - d0 + ferr_cnt - f0 + perr_cnt - p0), 32'd0);
      send_frame(8'h12, 1'b1, ^8'h12);
      hold(1'b1, 20);
      check("s5_next_frame", 32'(dout), 32'h12);
      check("s5_done_cnt", 32'(done_cnt - d0), 32'd1);

`ifdef UART_RX_PARITY_EN
      // Scenario 6: parity mismatch then a good frame of the same byte
      d0 = done_cnt; p0 = perr_cnt;
      send_frame(8'h07, 1'b1, 1'b0);
      hold(1'b1, 20);
      check("s6_perr", 32'(perr_cnt - p0), 32'd1);
      check("s6_dout_kept", 32'(dout), 32'h12);
      send_frame(8'h07, 1'b1, 1'b1);
      hold(1'b1, 20);
      check("s6_done", 32'(done_cnt - d0), 32'd1);
      check("s6_dout", 32'(dout), 32'h07);
`else
      check("perr_tied", 32'(perr_cnt), 32'd0);
`endif

      check("exclusive", 32'(excl_viol), 32'd0);
      check("one_cycle", 32'(width_viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
